// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not win last time. Bit 0 is the CPU, bit 1 the loader.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = (last == OWN_CPU) ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / loader arbiter for the shared data memory with loader burst locking.
//   state | meaning
//   ARB   | round-robin between CPU and loader
//   LOCK  | loader owns the memory; CPU forced in after BURST_MAX waits
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_w_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  arb_state_t       state_q, state_d;
  owner_t           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_gnt;
  logic             yield;

  logic              acc, acc_we;
  logic [ADDR_W-1:0] acc_adr;
  logic [DATA_W-1:0] acc_wdata;
  owner_t            cmd_tag, rsp_tag;

  dmem_rr_pick u_pick (
    .req  ({ldr_req, cpu_req}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      last_q  <= OWN_LDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    yield   = 1'b0;
    case (state_q)
      ARB: begin
        cpu_gnt = rr_gnt[0];
        ldr_gnt = rr_gnt[1];
        if (rr_gnt[0]) last_d = OWN_CPU;
        if (rr_gnt[1]) begin
          last_d = OWN_LDR;
          if (ldr_lock) begin
            state_d = LOCK;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCK: begin
        // A CPU that has sat through BURST_MAX locked grants goes first.
        yield = cpu_req && (cnt_q == CNT_MAX);
        if (yield)        cpu_gnt = 1'b1;
        else if (ldr_req) ldr_gnt = 1'b1;
        else              cpu_gnt = cpu_req;
        if (yield) begin
          state_d = ARB;
          cnt_d   = '0;
          last_d  = OWN_CPU;
        end else if (!ldr_lock) begin
          state_d = ARB;
          cnt_d   = '0;
          last_d  = OWN_LDR;
        end else if (ldr_req && cpu_req) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign acc       = cpu_gnt | ldr_gnt;
  assign acc_we    = ldr_gnt ? ldr_we    : cpu_we;
  assign acc_adr   = ldr_gnt ? ldr_addr  : cpu_addr;
  assign acc_wdata = ldr_gnt ? ldr_wdata : cpu_wdata;

  // cmd_tag tracks the read on mem_*; rsp_tag tracks the data on mem_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_w_en  <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      cmd_tag   <= OWN_NONE;
      rsp_tag   <= OWN_NONE;
    end else begin
      mem_w_en <= acc && acc_we;
      mem_r_en <= acc && !acc_we;
      if (acc) begin
        mem_adr   <= acc_adr;
        mem_wdata <= acc_wdata;
      end
      if (acc && !acc_we) cmd_tag <= ldr_gnt ? OWN_LDR : OWN_CPU;
      else                cmd_tag <= OWN_NONE;
      rsp_tag <= cmd_tag;
    end
  end

  assign cpu_rvalid = (rsp_tag == OWN_CPU);
  assign ldr_rvalid = (rsp_tag == OWN_LDR);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
  assign busy       = mem_w_en | mem_r_en | (rsp_tag != OWN_NONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus constrained
// random traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int BURST_MAX = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_t;

  localparam port_t IDLE = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic        mem_w_en, mem_r_en, busy;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous 16-word memory; garbage on rdata when not reading.
  logic [31:0] env_mem [16];
  always @(posedge clk) begin
    if (mem_w_en) env_mem[mem_adr[5:2]] <= mem_wdata;
    mem_rdata <= mem_r_en ? env_mem[mem_adr[5:2]] : $urandom;
  end

  // Reference model: arbitration bookkeeping plus an ordered view of memory.
  bit          m_last_cpu, m_locked;
  int          m_cnt, cpu_wait;
  logic [31:0] exp_mem [16];
  bit          e_w, e_r;
  logic [31:0] e_adr, e_wd, e_dat, r_dat;
  int          e_own, r_own;
  port_t       cur_c, cur_l;
  bit          cur_lk, e_cg, e_lg;
  int          checks = 0, fails = 0;

  function automatic port_t mk(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    port_t p;
    p.req = r; p.we = w; p.addr = a; p.wdata = d;
    return p;
  endfunction

  function automatic port_t rnd_port(input bit force_req);
    return mk(force_req || ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, $urandom, $urandom);
  endfunction

  function automatic logic [134:0] exp_vec();
    return {e_cg, e_lg, e_w, e_r, e_adr, e_wd,
            r_own == 1, (r_own == 1) ? r_dat : 32'h0,
            r_own == 2, (r_own == 2) ? r_dat : 32'h0,
            e_w | e_r | (r_own != 0)};
  endfunction

  function automatic logic [134:0] observed();
    return {cpu_gnt, ldr_gnt, mem_w_en, mem_r_en, mem_adr, mem_wdata,
            cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata, busy};
  endfunction

  task automatic model_reset();
    m_last_cpu = 0; m_locked = 0; m_cnt = 0; cpu_wait = 0;
    e_w = 0; e_r = 0; e_adr = '0; e_wd = '0; e_own = 0; e_dat = '0;
    r_own = 0; r_dat = '0; e_cg = 0; e_lg = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    cpu_req = 0; ldr_req = 0; ldr_lock = 0;
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // Drive one cycle's inputs at the falling edge and predict the grants.
  task automatic cycle_begin(input port_t c, input port_t l, input bit lk);
    @(negedge clk);
    cpu_req = c.req; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata;
    ldr_req = l.req; ldr_we = l.we; ldr_addr = l.addr; ldr_wdata = l.wdata;
    ldr_lock = lk;
    cur_c = c; cur_l = l; cur_lk = lk;
    #1;
    e_cg = 0; e_lg = 0;
    if (m_locked) begin
      if (c.req && m_cnt >= BURST_MAX) e_cg = 1;
      else if (l.req)                  e_lg = 1;
      else                             e_cg = c.req;
    end else if (c.req && l.req) begin
      e_cg = !m_last_cpu;
      e_lg = m_last_cpu;
    end else begin
      e_cg = c.req;
      e_lg = l.req;
    end
  endtask

  // Advance the model across the rising edge.
  task automatic cycle_end();
    port_t p;
    @(posedge clk);
    r_own = e_own;
    r_dat = e_dat;
    p = e_cg ? cur_c : cur_l;
    if (e_cg || e_lg) begin
      e_w = p.we; e_r = !p.we; e_adr = p.addr; e_wd = p.wdata;
      if (p.we) begin
        exp_mem[p.addr[5:2]] = p.wdata;
        e_own = 0;
      end else begin
        e_own = e_cg ? 1 : 2;
        e_dat = exp_mem[p.addr[5:2]];
      end
    end else begin
      e_w = 0; e_r = 0; e_own = 0;
    end
    cpu_wait = (cur_c.req && !e_cg) ? cpu_wait + 1 : 0;
    if (m_locked) begin
      if (e_cg && m_cnt >= BURST_MAX) begin
        m_locked = 0; m_cnt = 0; m_last_cpu = 1;
      end else if (!cur_lk) begin
        m_locked = 0; m_cnt = 0; m_last_cpu = 0;
      end else if (e_lg && cur_c.req) begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (e_cg) m_last_cpu = 1;
      if (e_lg) begin
        m_last_cpu = 0;
        if (cur_lk) begin m_locked = 1; m_cnt = 1; end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 0;
    model_reset();
    #2;
    checks++;
    if ({mem_w_en, mem_r_en, mem_adr, mem_wdata} !== 66'h0) begin
      fails++; $display("FAIL reset_mem: got %h want 0", {mem_w_en, mem_r_en, mem_adr, mem_wdata});
    end
    checks++;
    if ({cpu_rvalid, ldr_rvalid, busy, cpu_gnt, ldr_gnt} !== 5'b0) begin
      fails++; $display("FAIL reset_ctl: got %b want 00000", {cpu_rvalid, ldr_rvalid, busy, cpu_gnt, ldr_gnt});
    end
    @(negedge clk);
    rst = 1;
    cycle_begin(IDLE, IDLE, 0);
    checks++;
    if (observed() !== exp_vec()) begin
      fails++; $display("FAIL reset_idle: got %h want %h", observed(), exp_vec());
    end
    cycle_end();
  endtask

  task automatic test_preload();
    for (int i = 0; i < 18; i++) begin
      cycle_begin(IDLE, (i < 16) ? mk(1, 1, i * 4, $urandom) : IDLE, 0);
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL preload cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      cycle_end();
    end
  endtask

  task automatic test_round_robin();
    port_t c, l;
    apply_reset();
    c = rnd_port(1); l = rnd_port(1);
    for (int i = 0; i < 10; i++) begin
      cycle_begin(c, l, 0);
      checks++;
      if (cpu_gnt !== (i % 2 == 0) || ldr_gnt !== (i % 2 == 1)) begin
        fails++; $display("FAIL rr_order cyc %0d: got c=%b l=%b want c=%0d", i, cpu_gnt, ldr_gnt, i % 2 == 0);
      end
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL rr_vec cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      cycle_end();
      if (e_cg) c = rnd_port(1);
      if (e_lg) l = rnd_port(1);
    end
  endtask

  task automatic test_cpu_write_read();
    for (int i = 0; i < 5; i++) begin
      cycle_begin((i == 0) ? mk(1, 1, 32'h10, 32'hF0F0_F0F0) :
                  (i == 1) ? mk(1, 0, 32'h10, 32'h0) : IDLE, IDLE, 0);
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL wr_rd_vec cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (mem_w_en !== 1'b1 || mem_adr !== 32'h10 || mem_wdata !== 32'hF0F0_F0F0) begin
          fails++; $display("FAIL wr_strobe: got w=%b adr=%h d=%h want 1/10/f0f0f0f0", mem_w_en, mem_adr, mem_wdata);
        end
      end
      if (i == 3) begin
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hF0F0_F0F0 || ldr_rvalid !== 1'b0) begin
          fails++; $display("FAIL rd_return: got v=%b d=%h lv=%b want 1/f0f0f0f0/0", cpu_rvalid, cpu_rdata, ldr_rvalid);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_lock_burst();
    port_t c, l;
    apply_reset();
    c = rnd_port(1); l = rnd_port(1);
    for (int i = 0; i < 15; i++) begin
      cycle_begin(c, l, 1);
      checks++;
      if (cpu_gnt !== (i % 5 == 0) || ldr_gnt !== (i % 5 != 0)) begin
        fails++; $display("FAIL lock_order cyc %0d: got c=%b l=%b want c=%0d", i, cpu_gnt, ldr_gnt, i % 5 == 0);
      end
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL lock_vec cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      cycle_end();
      checks++;
      if (cpu_wait > BURST_MAX) begin
        fails++; $display("FAIL lock_starve cyc %0d: waited %0d want <= %0d", i, cpu_wait, BURST_MAX);
      end
      if (e_cg) c = rnd_port(1);
      if (e_lg) l = rnd_port(1);
    end
    for (int i = 0; i < 2; i++) begin
      cycle_begin(IDLE, IDLE, 0);
      cycle_end();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2, d3, want;
    logic [1:0]  wv;
    d1 = exp_mem[1]; d2 = exp_mem[2]; d3 = exp_mem[3];
    for (int j = 0; j < 6; j++) begin
      cycle_begin((j == 0) ? mk(1, 0, 32'h4, 32'h0) : (j == 2) ? mk(1, 0, 32'hC, 32'h0) : IDLE,
                  (j == 1) ? mk(1, 0, 32'h8, 32'h0) : IDLE, 0);
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL b2b_vec cyc %0d: got %h want %h", j, observed(), exp_vec());
      end
      if (j >= 2 && j <= 4) begin
        case (j)
          2:       begin wv = 2'b10; want = d1; end
          3:       begin wv = 2'b01; want = d2; end
          default: begin wv = 2'b10; want = d3; end
        endcase
        checks++;
        if ({cpu_rvalid, ldr_rvalid} !== wv || (cpu_rvalid ? cpu_rdata : ldr_rdata) !== want) begin
          fails++; $display("FAIL b2b_ret cyc %0d: got v=%b%b c=%h l=%h want v=%b d=%h",
                            j, cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata, wv, want);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_reset_inflight();
    cycle_begin(mk(1, 0, 32'h14, 32'h0), IDLE, 0);
    checks++;
    if (observed() !== exp_vec()) begin
      fails++; $display("FAIL rst_fl_issue: got %h want %h", observed(), exp_vec());
    end
    cycle_end();
    #2;
    checks++;
    if (mem_r_en !== 1'b1) begin
      fails++; $display("FAIL rst_fl_pre: got r_en=%b want 1", mem_r_en);
    end
    cpu_req = 0;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (mem_r_en !== 1'b0 || mem_w_en !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_fl_drop: got r=%b w=%b busy=%b want 0/0/0", mem_r_en, mem_w_en, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      cycle_begin(IDLE, IDLE, 0);
      checks++;
      if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0 || observed() !== exp_vec()) begin
        fails++; $display("FAIL rst_fl_quiet cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      cycle_end();
    end
    cycle_begin(mk(1, 0, 32'h4, 32'h0), mk(1, 0, 32'h8, 32'h0), 0);
    checks++;
    if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
      fails++; $display("FAIL rst_fl_tie: got c=%b l=%b want c=1 l=0", cpu_gnt, ldr_gnt);
    end
    cycle_end();
    for (int i = 0; i < 3; i++) begin
      cycle_begin(IDLE, IDLE, 0);
      cycle_end();
    end
  endtask

  task automatic test_idle();
    cycle_begin(mk(1, 1, 32'h3C, 32'h1234_5678), IDLE, 0);
    cycle_end();
    for (int i = 0; i < 10; i++) begin
      cycle_begin(IDLE, IDLE, 0);
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL idle_vec cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      if (i >= 1) begin
        checks++;
        if ({cpu_gnt, ldr_gnt, mem_w_en, mem_r_en, busy} !== 5'b0 ||
            mem_adr !== 32'h3C || mem_wdata !== 32'h1234_5678) begin
          fails++; $display("FAIL idle_hold cyc %0d: got ctl=%b adr=%h d=%h want 0/3c/12345678", i,
                            {cpu_gnt, ldr_gnt, mem_w_en, mem_r_en, busy}, mem_adr, mem_wdata);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_random();
    port_t c, l;
    bit    lk;
    c = IDLE; l = IDLE; lk = 0;
    for (int i = 0; i < 400; i++) begin
      if (!c.req || e_cg) c = rnd_port(0);
      if (!l.req || e_lg) l = rnd_port(0);
      if ($urandom_range(0, 7) == 0) lk = !lk;
      cycle_begin(c, l, lk);
      checks++;
      if (observed() !== exp_vec()) begin
        fails++; $display("FAIL rand_vec cyc %0d: got %h want %h", i, observed(), exp_vec());
      end
      cycle_end();
      checks++;
      if (cpu_wait > BURST_MAX) begin
        fails++; $display("FAIL rand_starve cyc %0d: waited %0d want <= %0d", i, cpu_wait, BURST_MAX);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_round_robin();
    test_cpu_write_read();
    test_lock_burst();
    test_back_to_back();
    test_reset_inflight();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
